color_grid_router: RTL

- Parametrised successor to the 4-quadrant colour processor.
- Holds a ROWS x COLS grid of latched colours and applies edge-triggered mirror/rotate transforms.
- Replicates cells per a display mode and presents registered per-cell colours to the pixel generator.
- Output updates can be held until the frame boundary to prevent tearing.

---
 rtl/color_grid_router.sv | 61 ++++++
 1 files changed

// File: rtl/color_grid_router.sv
// color_grid_router: ROWS x COLS colour grid with edge-triggered mirror/rotate, replication and frame-synced output
module color_grid_router #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int CW         = 24,
  parameter bit SYNC_FRAME = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     color_valid,
  input  logic [ROWS*COLS*CW-1:0]  rgb_in,
  input  logic                     swap_h,
  input  logic                     swap_v,
  input  logic                     rotate,
  input  logic [1:0]               mode,
  input  logic                     frame_start,
  output logic [ROWS*COLS*CW-1:0]  ch_out,
  output logic                     pending
);
  localparam int N = ROWS * COLS;
  localparam int W = N * CW;
  logic [W-1:0] grid_q, grid_d, ch_q, ch_d, view;
  logic [2:0]   prev_q, prev_d, flag_q, flag_d, cmd, clr;
  logic         pend_q, pend_d;
  assign cmd = {rotate, swap_v, swap_h};
  always_comb begin
    prev_d = cmd;
    // lowest set flag wins, giving h > v > rotate
    clr    = color_valid ? 3'b000 : flag_q & (~flag_q + 3'd1);
    flag_d = (flag_q & ~clr) | (cmd & ~prev_q);
    pend_d = |flag_d;
    grid_d = grid_q;
    view   = '0;
    for (int i = 0; i < N; i++) begin
      grid_d[i*CW +: CW] = color_valid ? rgb_in[i*CW +: CW] :
                           clr[0] ? grid_q[((i/COLS)*COLS + COLS-1-(i%COLS))*CW +: CW] :
                           clr[1] ? grid_q[((ROWS-1-(i/COLS))*COLS + (i%COLS))*CW +: CW] :
                           clr[2] ? grid_q[((i+1)%N)*CW +: CW] :
                           grid_q[i*CW +: CW];
      view[i*CW +: CW]   = grid_q[((mode[0] ? i/COLS : 0)*COLS + (mode[1] ? i%COLS : 0))*CW +: CW];
    end
    ch_d = (!SYNC_FRAME || frame_start) ? view : ch_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid_q <= '0;
      ch_q   <= '0;
      prev_q <= '0;
      flag_q <= '0;
      pend_q <= 1'b0;
    end else begin
      grid_q <= grid_d;
      ch_q   <= ch_d;
      prev_q <= prev_d;
      flag_q <= flag_d;
      pend_q <= pend_d;
    end
  end
  assign ch_out  = ch_q;
  assign pending = pend_q;
endmodule
